// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
// Runs the inhibit / request-to-send handshake, then shifts one byte out on device clock edges.
module ps2_host_tx #(
  parameter int unsigned SYS_CLK_HZ   = 100_000_000,
  parameter int unsigned INHIBIT_US   = 100,
  parameter int unsigned RTS_US       = 5,
  parameter int unsigned START_TMO_US = 15000,
  parameter int unsigned FRAME_TMO_US = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int unsigned CYC_PER_US  = SYS_CLK_HZ / 1_000_000;
  localparam int unsigned INHIBIT_CYC = CYC_PER_US * INHIBIT_US;
  localparam int unsigned RTS_CYC     = CYC_PER_US * RTS_US;
  localparam int unsigned START_CYC   = CYC_PER_US * START_TMO_US;
  localparam int unsigned FRAME_CYC   = CYC_PER_US * FRAME_TMO_US;
  localparam int unsigned MAX_AB      = (INHIBIT_CYC > RTS_CYC) ? INHIBIT_CYC : RTS_CYC;
  localparam int unsigned MAX_CD      = (START_CYC > FRAME_CYC) ? START_CYC : FRAME_CYC;
  localparam int unsigned MAX_CYC     = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  // Timers count down from N-1, so the widest load is MAX_CYC-1.
  localparam int          TMR_W       = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TMR_W-1:0] INHIBIT_LD = TMR_W'((INHIBIT_CYC > 0) ? INHIBIT_CYC - 1 : 0);
  localparam logic [TMR_W-1:0] RTS_LD     = TMR_W'((RTS_CYC > 0) ? RTS_CYC - 1 : 0);
  localparam logic [TMR_W-1:0] START_LD   = TMR_W'((START_CYC > 0) ? START_CYC - 1 : 0);
  localparam logic [TMR_W-1:0] FRAME_LD   = TMR_W'((FRAME_CYC > 0) ? FRAME_CYC - 1 : 0);
  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);

  localparam logic [1:0] ERR_NO_CLK    = 2'd1;
  localparam logic [1:0] ERR_FRAME_TMO = 2'd2;
  localparam logic [1:0] ERR_NO_ACK    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_WAIT_CLK,
    S_XFER,
    S_WAIT_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [3:0]       edge_cnt_q, edge_cnt_d;
  logic [7:0]       data_q, data_d;
  logic             parity_q, parity_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             fail;
  logic [1:0]       fail_code;
  logic [2:0]       bit_sel;

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic dat_meta_q, dat_sync_q;
  logic clk_fall;

  // Idle-high lines: synchronizers reset to 1 so reset release never looks like an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk_in;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_dat_in;
      dat_sync_q <= dat_meta_q;
    end
  end

  assign clk_fall = clk_prev_q & ~clk_sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      edge_cnt_q <= 4'd0;
      data_q     <= 8'h00;
      parity_q   <= 1'b0;
      err_code_q <= 2'd0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      edge_cnt_q <= edge_cnt_d;
      data_q     <= data_d;
      parity_q   <= parity_d;
      err_code_q <= err_code_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    edge_cnt_d = edge_cnt_q;
    data_d     = data_q;
    parity_d   = parity_q;
    err_code_d = err_code_q;
    fail       = 1'b0;
    fail_code  = 2'd0;
    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          data_d     = tx_data;
          parity_d   = ~^tx_data;
          err_code_d = 2'd0;
          edge_cnt_d = 4'd0;
          timer_d    = INHIBIT_LD;
          state_d    = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (timer_q == '0) begin
          timer_d = RTS_LD;
          state_d = S_RTS;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end
      S_RTS: begin
        if (timer_q == '0) begin
          timer_d = START_LD;
          state_d = S_WAIT_CLK;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end
      S_WAIT_CLK: begin
        if (clk_fall) begin
          edge_cnt_d = 4'd1;
          timer_d    = FRAME_LD;
          state_d    = S_XFER;
        end else if (timer_q == '0) begin
          fail      = 1'b1;
          fail_code = ERR_NO_CLK;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end
      S_XFER: begin
        if (timer_q == '0) begin
          fail      = 1'b1;
          fail_code = ERR_FRAME_TMO;
        end else begin
          timer_d = timer_q - TMR_ONE;
          if (clk_fall) begin
            // Edge 11 is the device's ACK slot: data must be held low.
            if (edge_cnt_q == 4'd10) begin
              edge_cnt_d = 4'd11;
              if (dat_sync_q) begin
                fail      = 1'b1;
                fail_code = ERR_NO_ACK;
              end else begin
                state_d = S_WAIT_IDLE;
              end
            end else begin
              edge_cnt_d = edge_cnt_q + 4'd1;
            end
          end
        end
      end
      S_WAIT_IDLE: begin
        if (clk_sync_q && dat_sync_q) begin
          state_d = S_IDLE;
        end else if (timer_q == '0) begin
          fail      = 1'b1;
          fail_code = ERR_FRAME_TMO;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (fail) begin
      state_d    = S_IDLE;
      err_code_d = fail_code;
    end
  end

  // Line drives follow the state being entered, so they change on the same edge as the state.
  always_comb begin
    clk_oe_d = 1'b0;
    dat_oe_d = 1'b0;
    bit_sel  = 3'(edge_cnt_d - 4'd1);
    case (state_d)
      S_INHIBIT:  clk_oe_d = 1'b1;
      S_RTS: begin
        clk_oe_d = 1'b1;
        dat_oe_d = 1'b1;
      end
      S_WAIT_CLK: dat_oe_d = 1'b1;
      S_XFER: begin
        if (edge_cnt_d <= 4'd8) begin
          dat_oe_d = ~data_q[bit_sel];
        end else if (edge_cnt_d == 4'd9) begin
          dat_oe_d = ~parity_q;
        end
      end
      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
      end
    endcase
    err_d  = fail;
    done_d = (state_q == S_WAIT_IDLE) && (state_d == S_IDLE) && !fail;
  end

  assign tx_ready   = (state_q == S_IDLE);
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx against a behavioural PS/2 device
// Runs at 1 MHz so one microsecond equals one system clock cycle.
module tb_ps2_host_tx;

  localparam int INHIBIT_CYC = 100;
  localparam int RTS_CYC     = 5;
  localparam int START_CYC   = 15000;
  localparam int FRAME_CYC   = 2000;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  logic       dev_clk  = 1'b1;
  logic       dev_dat  = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  bit exp_q[$];

  // Open-collector bus: either side can pull a line low.
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .SYS_CLK_HZ  (1_000_000),
    .INHIBIT_US  (100),
    .RTS_US      (5),
    .START_TMO_US(15000),
    .FRAME_TMO_US(2000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .done      (done),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (err === 1'b1) err_cnt <= err_cnt + 1;
  end

  task automatic push_frame(input logic [7:0] d);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    exp_q.push_back(~^d);
    exp_q.push_back(1'b1);
  endtask

  task automatic send(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    push_frame(d);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_release(output int inh, output int ovl);
    int t;
    inh = 0;
    ovl = 0;
    t   = 0;
    while (ps2_clk_oe === 1'b1 && t < 1000) begin
      if (ps2_dat_oe === 1'b1) ovl++;
      else inh++;
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (t >= 1000) begin
      n_fail++;
      $display("FAIL release_timeout: clk_oe still %b after %0d cycles, required 0", ps2_clk_oe, t);
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, t);
    end
  endtask

  // Device clocks 20 cycles low / 20 high and latches the data line at each rising edge.
  task automatic device_frame(input int n_edges, input bit ack);
    bit exp_b;
    repeat (10) @(negedge clk);
    for (int k = 0; k <= n_edges; k++) begin
      if (k > 0) begin
        if (k == 11 && ack) begin
          dev_dat = 1'b0;
          repeat (5) @(negedge clk);
        end
        dev_clk = 1'b0;
        repeat (20) @(negedge clk);
      end
      if (k <= 10) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL bit%0d: line=%b but scoreboard empty", k, ps2_dat_in);
        end else begin
          exp_b = exp_q.pop_front();
          if (ps2_dat_in !== exp_b) begin
            n_fail++;
            $display("FAIL bit%0d: line=%b required %b", k, ps2_dat_in, exp_b);
          end
        end
      end
      if (k > 0) begin
        dev_clk = 1'b1;
        if (k == n_edges) dev_dat = 1'b1;
        else repeat (20) @(negedge clk);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (tx_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_tx_ready: got %b required 1", tx_ready); end
    n_checks++; if (ps2_clk_oe !== 1'b0) begin n_fail++; $display("FAIL reset_clk_oe: got %b required 0", ps2_clk_oe); end
    n_checks++; if (ps2_dat_oe !== 1'b0) begin n_fail++; $display("FAIL reset_dat_oe: got %b required 0", ps2_dat_oe); end
    n_checks++; if (done !== 1'b0)       begin n_fail++; $display("FAIL reset_done: got %b required 0", done); end
    n_checks++; if (err !== 1'b0)        begin n_fail++; $display("FAIL reset_err: got %b required 0", err); end
    n_checks++; if (err_code !== 2'd0)   begin n_fail++; $display("FAIL reset_err_code: got %0d required 0", err_code); end
  endtask

  task automatic test_single_frame();
    int inh, ovl, d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'hED);
    wait_release(inh, ovl);
    n_checks++; if (inh !== INHIBIT_CYC) begin n_fail++; $display("FAIL inhibit_len: got %0d required %0d", inh, INHIBIT_CYC); end
    n_checks++; if (ovl !== RTS_CYC)     begin n_fail++; $display("FAIL rts_overlap: got %0d required %0d", ovl, RTS_CYC); end
    device_frame(11, 1'b1);
    wait_done();
    repeat (3) @(negedge clk);
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL ed_done_pulses: got %0d required 1", done_cnt - d0); end
    n_checks++; if (err_cnt - e0 !== 0)  begin n_fail++; $display("FAIL ed_err_pulses: got %0d required 0", err_cnt - e0); end
    n_checks++; if (err_code !== 2'd0)   begin n_fail++; $display("FAIL ed_err_code: got %0d required 0", err_code); end
    n_checks++; if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin
      n_fail++; $display("FAIL ed_lines_idle: got clk_oe=%b dat_oe=%b required 0 0", ps2_clk_oe, ps2_dat_oe);
    end
  endtask

  task automatic test_back_to_back();
    int inh, ovl, d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    tx_data  = 8'hED;
    tx_valid = 1'b1;
    push_frame(8'hED);
    @(negedge clk);
    tx_data = 8'hF4;
    n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_ready: got %b required 0", tx_ready); end
    wait_release(inh, ovl);
    device_frame(11, 1'b1);
    n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_wait_idle_ready: got %b required 0", tx_ready); end
    wait_done();
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_at_done: got %b required 1", tx_ready); end
    push_frame(8'hF4);
    @(negedge clk);
    tx_valid = 1'b0;
    n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_second_accept: got %b required 0", tx_ready); end
    wait_release(inh, ovl);
    n_checks++; if (inh !== INHIBIT_CYC) begin n_fail++; $display("FAIL b2b_inhibit_len: got %0d required %0d", inh, INHIBIT_CYC); end
    // Twelve device edges: the one after the ACK must be ignored.
    device_frame(12, 1'b1);
    wait_done();
    repeat (3) @(negedge clk);
    n_checks++; if (done_cnt - d0 !== 2) begin n_fail++; $display("FAIL b2b_done_pulses: got %0d required 2", done_cnt - d0); end
    n_checks++; if (err_cnt - e0 !== 0)  begin n_fail++; $display("FAIL b2b_err_pulses: got %0d required 0", err_cnt - e0); end
  endtask

  task automatic test_no_ack();
    int inh, ovl, d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'h00);
    wait_release(inh, ovl);
    device_frame(11, 1'b0);
    repeat (3) @(negedge clk);
    n_checks++; if (err_cnt - e0 !== 1)  begin n_fail++; $display("FAIL noack_err_pulses: got %0d required 1", err_cnt - e0); end
    n_checks++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL noack_done_pulses: got %0d required 0", done_cnt - d0); end
    n_checks++; if (err_code !== 2'd3)   begin n_fail++; $display("FAIL noack_err_code: got %0d required 3", err_code); end
    n_checks++; if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin
      n_fail++; $display("FAIL noack_lines: got clk_oe=%b dat_oe=%b required 0 0", ps2_clk_oe, ps2_dat_oe);
    end
  endtask

  task automatic test_frame_timeout();
    int inh, ovl, e0, t, n;
    e0 = err_cnt;
    send(8'hED);
    wait_release(inh, ovl);
    t = 0;
    n = 0;
    fork
      device_frame(4, 1'b1);
      begin
        // Bit 0 of 0xED is 1, so the data line is released on the DUT's first-edge cycle.
        while (ps2_dat_oe !== 1'b0 && t < 2000) begin
          @(negedge clk);
          t++;
        end
        while (err !== 1'b1 && n < 5000) begin
          @(negedge clk);
          n++;
        end
        n_checks++; if (n !== FRAME_CYC) begin n_fail++; $display("FAIL frame_tmo_latency: got %0d required %0d", n, FRAME_CYC); end
        n_checks++; if (err_code !== 2'd2) begin n_fail++; $display("FAIL frame_tmo_code: got %0d required 2", err_code); end
        n_checks++; if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin
          n_fail++; $display("FAIL frame_tmo_lines: got clk_oe=%b dat_oe=%b required 0 0", ps2_clk_oe, ps2_dat_oe);
        end
      end
    join
    repeat (3) @(negedge clk);
    n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL frame_tmo_pulses: got %0d required 1", err_cnt - e0); end
  endtask

  task automatic test_no_clock();
    int inh, ovl, t;
    send(8'h55);
    exp_q.delete();
    wait_release(inh, ovl);
    t = 0;
    while (err !== 1'b1 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    n_checks++; if (t !== START_CYC)   begin n_fail++; $display("FAIL noclk_latency: got %0d required %0d", t, START_CYC); end
    n_checks++; if (err_code !== 2'd1) begin n_fail++; $display("FAIL noclk_code: got %0d required 1", err_code); end
    n_checks++; if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin
      n_fail++; $display("FAIL noclk_lines: got clk_oe=%b dat_oe=%b required 0 0", ps2_clk_oe, ps2_dat_oe);
    end
  endtask

  task automatic test_reset_mid_frame();
    int inh, ovl, d0, e0;
    send(8'hED);
    exp_q.delete();
    wait_release(inh, ovl);
    repeat (10) @(negedge clk);
    for (int k = 1; k <= 5; k++) begin
      dev_clk = 1'b0;
      repeat (20) @(negedge clk);
      if (k < 5) begin
        dev_clk = 1'b1;
        repeat (20) @(negedge clk);
      end
    end
    // Bit 4 of 0xED is 0, so the host is pulling data low here.
    n_checks++; if (ps2_dat_oe !== 1'b1) begin n_fail++; $display("FAIL rst_pre_dat_oe: got %b required 1", ps2_dat_oe); end
    d0 = done_cnt;
    e0 = err_cnt;
    #2 rst = 1'b0;
    #1;
    n_checks++; if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin
      n_fail++; $display("FAIL rst_async_release: got clk_oe=%b dat_oe=%b required 0 0", ps2_clk_oe, ps2_dat_oe);
    end
    @(negedge clk);
    rst     = 1'b1;
    dev_clk = 1'b1;
    repeat (50) @(negedge clk);
    n_checks++; if (tx_ready !== 1'b1)   begin n_fail++; $display("FAIL rst_tx_ready: got %b required 1", tx_ready); end
    n_checks++; if (err_code !== 2'd0)   begin n_fail++; $display("FAIL rst_err_code: got %0d required 0", err_code); end
    n_checks++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL rst_done_pulses: got %0d required 0", done_cnt - d0); end
    n_checks++; if (err_cnt - e0 !== 0)  begin n_fail++; $display("FAIL rst_err_pulses: got %0d required 0", err_cnt - e0); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_no_ack();
    test_frame_timeout();
    test_no_clock();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
